// File: rtl/mdu_issue_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_issue_ctrl_pkg : instr_type codes, FSM states, MDU latencies      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mdu_issue_ctrl_pkg;

  localparam int TYPE_W_DEF   = 6;
  localparam int WDOG_MAX_DEF = 15;

  localparam logic [TYPE_W_DEF-1:0] OP_NOP   = 6'd0;
  localparam logic [TYPE_W_DEF-1:0] OP_MULT  = 6'd1;
  localparam logic [TYPE_W_DEF-1:0] OP_MULTU = 6'd2;
  localparam logic [TYPE_W_DEF-1:0] OP_DIV   = 6'd3;
  localparam logic [TYPE_W_DEF-1:0] OP_DIVU  = 6'd4;
  localparam logic [TYPE_W_DEF-1:0] OP_MTHI  = 6'd5;
  localparam logic [TYPE_W_DEF-1:0] OP_MTLO  = 6'd6;
  localparam logic [TYPE_W_DEF-1:0] OP_MFHI  = 6'd7;
  localparam logic [TYPE_W_DEF-1:0] OP_MFLO  = 6'd8;

  // Busy durations the MDU uses; shared so both sides agree on timing.
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_BUSY   = 2'd2
  } state_t;

  function automatic logic is_long(input logic [TYPE_W_DEF-1:0] t);
    return (t == OP_MULT) || (t == OP_MULTU) || (t == OP_DIV) || (t == OP_DIVU);
  endfunction

  function automatic logic is_mducls(input logic [TYPE_W_DEF-1:0] t);
    return is_long(t) || (t == OP_MTHI) || (t == OP_MTLO) ||
           (t == OP_MFHI) || (t == OP_MFLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_issue_ctrl_if : E/D-stage, MDU start/busy and stall signals       |
// | Optional counters under MDU_STALL_PERF_EN.  Rev 1.0                   |
// +----------------------------------------------------------------------+
interface mdu_issue_ctrl_if #(
  parameter int TYPE_W = 6
) ();

  logic              Req;
  logic              e_valid;
  logic [TYPE_W-1:0] e_instr_type;
  logic              d_valid;
  logic [TYPE_W-1:0] d_instr_type;
  logic              mdu_busy;
  logic              mdu_start;
  logic [TYPE_W-1:0] mdu_instr_type;
  logic              stall_d;
  logic              mdu_err;
`ifdef MDU_STALL_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       mdu_ops;
`endif

  modport master (
    input  Req, e_valid, e_instr_type, d_valid, d_instr_type, mdu_busy,
    output mdu_start, mdu_instr_type, stall_d, mdu_err
`ifdef MDU_STALL_PERF_EN
    , output stall_cycles, mdu_ops
`endif
  );

  modport slave (
    output Req, e_valid, e_instr_type, d_valid, d_instr_type, mdu_busy,
    input  mdu_start, mdu_instr_type, stall_d, mdu_err
`ifdef MDU_STALL_PERF_EN
    , input stall_cycles, mdu_ops
`endif
  );

endinterface
`default_nettype wire

// File: rtl/mdu_issue_ctrl_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_issue_ctrl_wdog : saturating cycle counter with limit trip        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mdu_issue_ctrl_wdog #(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  input  wire logic [CNT_W-1:0] i_limit,
  output logic                  o_trip
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_trip = i_en & (r_cnt == i_limit);

endmodule
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_issue_ctrl : E-stage MDU start/busy initiator and D-stage stall   |
// | Optional stall/op counters under MDU_STALL_PERF_EN.  Rev 1.0          |
// +----------------------------------------------------------------------+
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int TYPE_W   = TYPE_W_DEF,
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mdu_issue_ctrl_if.master bus
);

  localparam int c_WDOG_W = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_err;
  logic   w_e_live;
  logic   w_e_long;
  logic   w_proto_err;
  logic   w_err_trip;
  logic   w_start;
  logic   w_stall;
  logic   w_wdog_en;
  logic   w_wdog_trip;

  assign w_e_live    = bus.e_valid & ~bus.Req & ~reset;
  assign w_e_long    = bus.e_valid & is_long(bus.e_instr_type);
  assign w_proto_err = (w_e_long & (r_state != ST_IDLE)) |
                       (bus.mdu_busy & (r_state == ST_IDLE));
  assign w_err_trip  = w_proto_err | w_wdog_trip;
  assign w_start     = w_e_live & w_e_long & (r_state == ST_IDLE) & ~w_err_trip;

  // Stall covers the start cycle too, before the MDU has raised busy.
  assign w_stall = ~reset & bus.d_valid & is_mducls(bus.d_instr_type) &
                   (w_start | (r_state != ST_IDLE) | bus.mdu_busy);

  assign w_wdog_en = (r_state == ST_BUSY) & bus.mdu_busy;

  mdu_issue_ctrl_wdog #(
    .CNT_W (c_WDOG_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (~w_wdog_en),
    .i_en    (w_wdog_en),
    .i_limit (c_WDOG_W'(WDOG_MAX)),
    .o_trip  (w_wdog_trip)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_ISSUED;
      ST_ISSUED: w_state_nxt = bus.mdu_busy ? ST_BUSY : ST_IDLE;
      ST_BUSY:   if (w_wdog_trip || !bus.mdu_busy) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_err_trip;
    end
  end

  assign bus.mdu_start      = w_start;
  assign bus.mdu_instr_type = w_e_live ? bus.e_instr_type : TYPE_W'(OP_NOP);
  assign bus.stall_d        = w_stall;
  assign bus.mdu_err        = r_err & ~reset;

`ifdef MDU_STALL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_mdu_ops;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_mdu_ops      <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_start && (r_mdu_ops != '1))      r_mdu_ops      <= r_mdu_ops + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.mdu_ops      = r_mdu_ops;
`endif

endmodule
`default_nettype wire
